// File: rtl/digit_fifo_sc_xn.sv
// Lockstep N-digit residue FIFO: one shared pointer set, registered status flags and sticky errors.
// Read latency 1 clk; a write at full is only taken alongside a read, and a read at empty is refused.
module digit_fifo_sc_xn #(
    parameter  int NUM_DIG   = 10,
    parameter  int DIG_W     = 18,
    parameter  int DEPTH     = 256,
    parameter  int AFULL_TH  = 240,
    parameter  int AEMPTY_TH = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int WW        = NUM_DIG * DIG_W
) (
    input  logic          clk,
    input  logic          sync_clr,
    input  logic          flush,
    input  logic          err_clr,
    input  logic          wr_req,
    input  logic [WW-1:0] din,
    input  logic          rd_req,
    output logic [WW-1:0] dout,
    output logic          dout_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   used,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_V    = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_V    = (AW+1)'(AEMPTY_TH);

    logic [WW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   used_q, used_d;
    logic [WW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_acc, wr_acc;

    always_comb begin
        rd_acc       = rd_req & ~empty_q;
        wr_acc       = wr_req & (~full_q | rd_acc);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        used_d       = used_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q;
        udf_d        = udf_q;

        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                dout_d       = mem[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
            used_d = used_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
            // A rejection in the same cycle as err_clr must still be recorded.
            if (wr_req & ~wr_acc) ovf_d = 1'b1;
            if (rd_req & ~rd_acc) udf_d = 1'b1;
        end

        empty_d  = (used_d == '0);
        full_d   = (used_d == DEPTH_V);
        afull_d  = (used_d >= AF_V);
        aempty_d = (used_d <= AE_V);
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Storage is never cleared, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!sync_clr && !flush && wr_acc) mem[wr_ptr_q] <= din;
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign used         = used_q;
    assign ovf_err      = ovf_q;
    assign udf_err      = udf_q;

endmodule

// File: tb/tb_digit_fifo_sc_xn.sv
// Randomised and directed bench for digit_fifo_sc_xn with a queue-based reference model and read-data scoreboard.
module tb_digit_fifo_sc_xn;

    localparam int NUM_DIG = 10;
    localparam int DIG_W   = 18;
    localparam int DEPTH   = 8;
    localparam int AF_TH   = 6;
    localparam int AE_TH   = 1;
    localparam int AW      = $clog2(DEPTH);
    localparam int WW      = NUM_DIG * DIG_W;

    logic          clk = 1'b0;
    logic          sync_clr = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [WW-1:0] din = '0;
    logic [WW-1:0] dout;
    logic          dout_valid, empty, full, almost_full, almost_empty, ovf_err, udf_err;
    logic [AW:0]   used;

    digit_fifo_sc_xn #(
        .NUM_DIG(NUM_DIG), .DIG_W(DIG_W), .DEPTH(DEPTH),
        .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
    ) dut (
        .clk(clk), .sync_clr(sync_clr), .flush(flush), .err_clr(err_clr),
        .wr_req(wr_req), .din(din), .rd_req(rd_req),
        .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .used(used),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus expected output registers.
    logic [WW-1:0] mq[$];
    logic [WW-1:0] sb[$];
    logic [WW-1:0] m_dout = '0;
    bit            m_vld = 0, m_ovf = 0, m_udf = 0;
    bit            armed = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [WW-1:0] mk_word(input int i);
        logic [WW-1:0] w = '0;
        for (int k = 0; k < NUM_DIG; k++) w[k*DIG_W +: DIG_W] = DIG_W'(i*16 + k);
        return w;
    endfunction

    function automatic logic [WW-1:0] rnd_word();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[WW-1:0];
    endfunction

    // Drive one cycle of inputs, then advance the model across the edge.
    task automatic cyc(input bit wr, input bit rd, input logic [WW-1:0] d,
                       input bit fl = 0, input bit clr = 0, input bit ec = 0);
        bit rd_ok, wr_ok;
        wr_req = wr; rd_req = rd; din = d; flush = fl; sync_clr = clr; err_clr = ec;
        @(posedge clk);
        if (clr) begin
            mq.delete(); sb.delete();
            m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
            armed = 1;
        end else begin
            if (ec) begin m_ovf = 0; m_udf = 0; end
            if (fl) begin
                mq.delete();
                m_vld = 0;
            end else begin
                rd_ok = rd && mq.size() > 0;
                wr_ok = wr && (mq.size() < DEPTH || rd_ok);
                if (rd_ok) begin
                    m_dout = mq.pop_front();
                    sb.push_back(m_dout);
                end
                m_vld = rd_ok;
                if (wr_ok) mq.push_back(d);
                if (wr && !wr_ok) m_ovf = 1;
                if (rd && !rd_ok) m_udf = 1;
            end
        end
        #1;
        wr_req = 0; rd_req = 0; flush = 0; sync_clr = 0; err_clr = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (armed) begin
            chk("dout_valid", int'(dout_valid), int'(m_vld));
            if (dout_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_underrun: dout_valid with no expected word, dout=%h", dout);
                end else begin
                    n_pass++;
                    chkw("dout_data", dout, sb.pop_front());
                end
            end
            chkw("dout_hold", dout, m_dout);
            chk("used", int'(used), mq.size());
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(mq.size() >= AF_TH));
            chk("almost_empty", int'(almost_empty), int'(mq.size() <= AE_TH));
            chk("ovf_err", int'(ovf_err), int'(m_ovf));
            chk("udf_err", int'(udf_err), int'(m_udf));
        end
    end

    logic [WW-1:0] ones;

    initial begin
        ones = '1;
        repeat (2) @(posedge clk);
        #1;
        // 1: reset, fill, overflow
        cyc(0, 0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, mk_word(i));
        cyc(1, 0, mk_word(99));
        // 2: drain, underflow, dout holds word 7
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0);
        cyc(0, 1, '0);
        cyc(0, 0, '0);
        chkw("hold_word7", dout, mk_word(7));
        // 3: full with simultaneous read+write across wrap
        cyc(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, mk_word(20 + i));
        for (int i = 0; i < 4; i++) cyc(1, 1, mk_word(40 + i));
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0);
        // 4: write+read at empty takes only the write
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 1, ones);
        cyc(0, 1, '0);
        cyc(0, 0, '0);
        chkw("all_ones_read", dout, ones);
        // 5: flush with a same-cycle write
        cyc(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, mk_word(60 + i));
        cyc(1, 1, mk_word(70), 1);
        cyc(1, 0, mk_word(71));
        cyc(0, 1, '0);
        cyc(0, 0, '0);
        chkw("post_flush_word", dout, mk_word(71));
        // 6: errors set, sync_clr mid-stream, then err_clr alone
        cyc(0, 1, '0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, mk_word(80 + i));
        cyc(1, 0, mk_word(90));
        for (int i = 0; i < 5; i++) cyc(0, 1, '0);
        cyc(1, 1, mk_word(91), 0, 1);
        cyc(0, 0, '0);
        cyc(0, 1, '0);
        for (int i = 0; i < 3; i++) cyc(1, 0, mk_word(100 + i));
        cyc(0, 0, '0, 0, 0, 1);
        // Random traffic with drifting write/read bias
        for (int n = 0; n < 1500; n++) begin
            int pw, pr, r;
            pw = ((n / 100) % 2 == 0) ? 70 : 30;
            pr = 100 - pw;
            r  = $urandom_range(999);
            cyc($urandom_range(99) < pw, $urandom_range(99) < pr, rnd_word(),
                r < 15, r >= 995, (r >= 15 && r < 45));
        end
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
